// File: rtl/sevenseg_scan_if.sv
// sevenseg_scan_if
//   Bundles the digit inputs, scan controls and display outputs of the
//   stopwatch seven-segment driver.
//   master : digit/control source (drives en, blank_lz and the BCD digits,
//            observes seg/an).
//   slave  : the scan driver (consumes digits/controls, drives seg/an).
//   Signals:
//     en        scan enable; low holds the scan and blanks the display
//     blank_lz  blank a minutes-tens digit of 0 (sampled live)
//     min_tens  BCD digit 3    min_ones  BCD digit 2
//     sec_tens  BCD digit 1    sec_ones  BCD digit 0
//     seg       {g,f,e,d,c,b,a}, active-low
//     an        digit anodes, active-low, an[i] selects digit i
// Handshake: there is no valid/ready pair here. The digit inputs are level
// signals that are sampled only at the frame-wrap edge; the consumer never
// back-pressures the source.
interface sevenseg_scan_if;
   logic       en;
   logic       blank_lz;
   logic [3:0] min_tens;
   logic [3:0] min_ones;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic [6:0] seg;
   logic [3:0] an;

   modport master (
      output en, blank_lz, min_tens, min_ones, sec_tens, sec_ones,
      input  seg, an
   );

   modport slave (
      input  en, blank_lz, min_tens, min_ones, sec_tens, sec_ones,
      output seg, an
   );
endinterface

// File: rtl/sevenseg_scan.sv
// sevenseg_scan
//   Time-multiplexed four-digit seven-segment driver. A prescaler divides
//   each digit slot into REFRESH_DIV cycles; a 2-bit slot index walks the
//   digits 0..3. The four BCD inputs are snapshotted once per frame (at the
//   frame-wrap edge) so a frame never shows a mix of old and new digits.
//   The first GUARD cycles of every slot keep all anodes off to suppress
//   ghosting, while seg already carries the new digit.
// Parameters:
//   REFRESH_DIV  cycles per digit slot (>= 2)
//   GUARD        anode-off cycles at the start of each slot (< REFRESH_DIV)
// Ports:
//   clk  clock
//   rst  asynchronous, active-high reset
//   bus  sevenseg_scan_if.slave (digits, en, blank_lz in; seg, an out)
module sevenseg_scan #(
   parameter int REFRESH_DIV = 1000,
   parameter int GUARD       = 2
) (
   input logic            clk,
   input logic            rst,
   sevenseg_scan_if.slave bus
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   // snap_q[i] holds digit i (0 = sec_ones ... 3 = min_tens).
   logic [3:0][3:0]  snap_q, snap_d;
   logic [6:0]       seg_q, seg_d;
   logic [3:0]       an_q, an_d;

   logic             slot_last;
   logic [3:0]       cur_digit;

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;  // non-BCD codes show a dash
      endcase
      return s;
   endfunction

   always_comb begin
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      snap_d    = snap_q;
      seg_d     = 7'b1111111;
      an_d      = 4'b1111;
      slot_last = (cnt_q == CNT_LAST);
      cur_digit = snap_q[idx_q];

      if (bus.en) begin
         cnt_d = slot_last ? '0 : cnt_q + CNT_W'(1);
         if (slot_last) begin
            idx_d = idx_q + 2'd1;
            // Frame wrap: take a coherent copy of all four digits.
            if (idx_q == 2'd3) begin
               snap_d = {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
            end
         end

         // Segments follow the selected digit even during the guard so they
         // are settled by the time the anode turns on.
         if (bus.blank_lz && (idx_q == 2'd3) && (cur_digit == 4'd0)) begin
            seg_d = 7'b1111111;
         end else begin
            seg_d = decode(cur_digit);
         end

         if (int'(cnt_q) < GUARD) begin
            an_d = 4'b1111;
         end else begin
            an_d = ~(4'b0001 << idx_q);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         idx_q  <= 2'd0;
         snap_q <= '0;
         seg_q  <= 7'b1111111;
         an_q   <= 4'b1111;
      end else begin
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         snap_q <= snap_d;
         seg_q  <= seg_d;
         an_q   <= an_d;
      end
   end

   assign bus.seg = seg_q;
   assign bus.an  = an_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan
//   Directed bench for sevenseg_scan with REFRESH_DIV=4, GUARD=1. Every
//   slot is 4 cycles: one guard cycle (an=1111) then three cycles with the
//   one-cold anode; seg carries the digit in all four.
module tb_sevenseg_scan;

   localparam logic [6:0] S0    = 7'b1000000;
   localparam logic [6:0] S1    = 7'b1111001;
   localparam logic [6:0] S2    = 7'b0100100;
   localparam logic [6:0] S3    = 7'b0110000;
   localparam logic [6:0] S4    = 7'b0011001;
   localparam logic [6:0] S5    = 7'b0010010;
   localparam logic [6:0] S7    = 7'b1111000;
   localparam logic [6:0] DASH  = 7'b0111111;
   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [3:0] AOFF  = 4'b1111;
   localparam logic [3:0] A0    = 4'b1110;
   localparam logic [3:0] A1    = 4'b1101;
   localparam logic [3:0] A2    = 4'b1011;
   localparam logic [3:0] A3    = 4'b0111;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   sevenseg_scan_if bus ();

   sevenseg_scan #(
      .REFRESH_DIV (4),
      .GUARD       (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
      n_checks++;
      assert (bus.an === exp_an && bus.seg === exp_seg) else begin
         n_fail++;
         $error("FAIL %s: an=%b seg=%b, expected an=%b seg=%b",
                tag, bus.an, bus.seg, exp_an, exp_seg);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full slot: guard cycle then three lit cycles.
   task automatic slot(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
      step();
      chk({tag, "_guard"}, AOFF, exp_seg);
      for (int i = 0; i < 3; i++) begin
         step();
         chk({tag, "_lit"}, exp_an, exp_seg);
      end
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      rst          = 1'b1;
      bus.en       = 1'b1;
      bus.blank_lz = 1'b0;
      bus.min_tens = 4'd1;
      bus.min_ones = 4'd2;
      bus.sec_tens = 4'd3;
      bus.sec_ones = 4'd4;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_hold", AOFF, BLANK);
      rst = 1'b0;

      // Frame 1: snapshot still all zero.
      slot("f1_d0", A0, S0);
      slot("f1_d1", A1, S0);
      slot("f1_d2", A2, S0);
      slot("f1_d3", A3, S0);

      // Frame 2: live digits 1,2,3,4.
      slot("f2_d0", A0, S4);
      slot("f2_d1", A1, S3);
      slot("f2_d2", A2, S2);
      slot("f2_d3", A3, S1);

      // Frame 3: change sec_ones during slot 1; not visible this frame.
      slot("f3_d0", A0, S4);
      bus.sec_ones = 4'd7;
      slot("f3_d1", A1, S3);
      slot("f3_d2", A2, S2);
      slot("f3_d3", A3, S1);

      // Frame 4: new sec_ones appears; stage leading zero and dash inputs.
      slot("f4_d0", A0, S7);
      bus.min_tens = 4'd0;
      bus.min_ones = 4'd12;
      bus.blank_lz = 1'b1;
      slot("f4_d1", A1, S3);
      slot("f4_d2", A2, S2);
      slot("f4_d3_noblank", A3, S1);

      // Frame 5: dash on digit 2, blanked leading zero on digit 3.
      slot("f5_d0", A0, S7);
      slot("f5_d1", A1, S3);
      slot("f5_dash", A2, DASH);
      slot("f5_lz_blank", A3, BLANK);

      // Frame 6: blank_lz dropped live before slot 3.
      slot("f6_d0", A0, S7);
      slot("f6_d1", A1, S3);
      slot("f6_dash", A2, DASH);
      bus.blank_lz = 1'b0;
      slot("f6_lz_shown", A3, S0);

      // Frame 7: enable hold at idx=2, cnt=1.
      slot("f7_d0", A0, S7);
      slot("f7_d1", A1, S3);
      step();
      chk("hold_pre_guard", AOFF, DASH);
      bus.en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("hold_blank", AOFF, BLANK);
      end
      bus.en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold_resume", A2, DASH);
      end
      bus.sec_ones = 4'd5;
      step();
      chk("wrap_d3_guard", AOFF, S0);
      step();
      chk("wrap_d3_c1", A3, S0);
      step();
      chk("wrap_d3_c2", A3, S0);

      // Now at idx=3, cnt=3: disable exactly on the wrap cycle.
      bus.en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("wrap_hold", AOFF, BLANK);
      end
      bus.en = 1'b1;
      step();
      chk("wrap_resume_d3", A3, S0);
      slot("f8_d0_loaded", A0, S5);
      slot("f8_d1", A1, S3);

      // Reset mid-slot: immediate blank, then restart from idx 0 with zeros.
      step();
      chk("pre_reset", AOFF, DASH);
      rst = 1'b1;
      #1;
      chk("reset_async", AOFF, BLANK);
      @(negedge clk);
      rst = 1'b0;
      step();
      chk("post_reset_guard", AOFF, S0);
      step();
      chk("post_reset_d0", A0, S0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
